// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decode plus an iterative multiply/divide
// unit (mult, multu, div, divu) with architectural HI/LO and mfhi/mflo read-out.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MDU_EARLY_TERM_EN: a multiply finishes as soon as the
// remaining multiplier bits are all zero, instead of always running WIDTH steps.
module alu_ctrl_mdu #(
  parameter int WIDTH = 32,  // operand and HI/LO width, even and >= 4
  parameter int CNT_W = 6    // iteration counter width, 2**CNT_W > WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [1:0]       aluop,
  input  logic             issue,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       aluctrl,
  output logic             md_busy,
  output logic             md_done,
  output logic             stall,
  output logic             hilo_rd,
  output logic [WIDTH-1:0] hilo_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand magnitude, shifts left
  logic [2*WIDTH-1:0] prod_q;    // product magnitude accumulator
  logic [WIDTH-1:0]   mplier_q;  // remaining multiplier bits, shifts right
  logic [WIDTH-1:0]   quo_q;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   rem_q;     // partial remainder
  logic [WIDTH-1:0]   dvsr_q;    // divisor magnitude
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_a_q, neg_b_q;
  logic               md_busy_q, md_done_q;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic r_type, md_op;

  assign r_type    = (aluop == 2'b10) && (op == 6'b000000);
  assign md_op     = r_type && (funct[5:2] == 4'b0110);
  assign hilo_rd   = r_type && ((funct == 6'b010000) || (funct == 6'b010010));
  assign hilo_data = hilo_rd ? (funct[1] ? lo_q : hi_q) : '0;
  assign stall     = issue & (md_op | hilo_rd) & (state_q != S_IDLE);

  assign md_busy = md_busy_q;
  assign md_done = md_done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

  // ALU control decode from aluop/op/funct
  always_comb begin
    // NOTE: default first so every path assigns aluctrl and no latch is inferred.
    aluctrl = 3'b000;
    case (aluop)
      2'b01: aluctrl = 3'b001;
      2'b11: aluctrl = 3'b111;
      2'b10: begin
        if (op == 6'b000000) begin
          case (funct)
            6'b100000: aluctrl = 3'b000;  // add
            6'b100010: aluctrl = 3'b001;  // sub
            6'b100100: aluctrl = 3'b010;  // and
            6'b100101: aluctrl = 3'b011;  // or
            6'b100110: aluctrl = 3'b100;  // xor
            6'b100111: aluctrl = 3'b101;  // nor
            6'b101010: aluctrl = 3'b110;  // slt
            default:   aluctrl = 3'b000;
          endcase
        end else begin
          case (op)
            6'b001000: aluctrl = 3'b000;  // addi
            6'b001100: aluctrl = 3'b010;  // andi
            6'b001101: aluctrl = 3'b011;  // ori
            6'b001110: aluctrl = 3'b100;  // xori
            6'b001010: aluctrl = 3'b110;  // slti
            default:   aluctrl = 3'b000;
          endcase
        end
      end
      default: aluctrl = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand magnitudes. funct[0]=0 selects the signed forms (mult, div).
  // An unsigned WIDTH-bit magnitude holds 2**(WIDTH-1), so the most negative
  // operand needs no special case.
  // ---------------------------------------------------------------------------
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed = ~funct[0];
  assign a_neg     = is_signed & src_a[WIDTH-1];
  assign b_neg     = is_signed & src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  // ---------------------------------------------------------------------------
  // Restoring divide step. The partial remainder is always below the divisor
  // (or, for a zero divisor, has at most WIDTH-1 significant bits), so bit
  // WIDTH of trial-divisor is set exactly when the subtraction would borrow.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   trial, sub;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;

  assign trial    = {rem_q, quo_q[WIDTH-1]};
  assign sub      = trial - {1'b0, dvsr_q};
  assign q_bit    = ~sub[WIDTH];
  assign rem_step = q_bit ? sub[WIDTH-1:0] : trial[WIDTH-1:0];

  // Iteration end conditions; the last MUL/DIV cycle writes HI/LO instead of stepping.
  logic mul_last, div_last;

`ifdef MDU_EARLY_TERM_EN
  assign mul_last = (cnt_q == LAST_CNT) || ((cnt_q != '0) && (mplier_q == '0));
`else
  assign mul_last = (cnt_q == LAST_CNT);
`endif
  assign div_last = (cnt_q == LAST_CNT);

  // Sign correction. A zero divisor forces an all-ones quotient; the remainder
  // path already reproduces src_a in that case.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
  assign quo_fix  = (dvsr_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -quo_q : quo_q);
  assign rem_fix  = neg_a_q ? -rem_q : rem_q;

  // Control FSM: state, iteration count, operand signs and the busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout clocked logic so every
      // register samples the pre-edge values, independent of statement order.
      md_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue && md_op) begin
            state_q   <= funct[1] ? S_DIV : S_MUL;
            cnt_q     <= '0;
            neg_a_q   <= a_neg;
            neg_b_q   <= b_neg;
            md_busy_q <= 1'b1;
          end
        end
        S_MUL: begin
          if (mul_last) begin
            state_q   <= S_DONE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (div_last) begin
            state_q   <= S_DONE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, one multiply/divide step per cycle, HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue && md_op) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            prod_q   <= '0;
            mplier_q <= b_mag;
            quo_q    <= a_mag;
            rem_q    <= '0;
            dvsr_q   <= b_mag;
          end
        end
        S_MUL: begin
          if (mul_last) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else begin
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          end
        end
        S_DIV: begin
          if (div_last) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            quo_q <= {quo_q[WIDTH-2:0], q_bit};
            rem_q <= rem_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: self-checking bench for alu_ctrl_mdu (WIDTH=32).
// Expected HI/LO and latency are queued when an MD op is accepted and popped
// by a monitor when md_done pulses.
module tb_alu_ctrl_mdu;

  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   op = '0;
  logic [5:0]   funct = '0;
  logic [1:0]   aluop = '0;
  logic         issue = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [2:0]   aluctrl;
  logic         md_busy, md_done, stall, hilo_rd;
  logic [W-1:0] hilo_data, hi, lo;

  alu_ctrl_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct     (funct),
    .aluop     (aluop),
    .issue     (issue),
    .src_a     (src_a),
    .src_b     (src_b),
    .aluctrl   (aluctrl),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .stall     (stall),
    .hilo_rd   (hilo_rd),
    .hilo_data (hilo_data),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: one entry per accepted MD op
  string        tag_q[$];
  logic [63:0]  hilo_q[$];
  int           lat_q[$];
  int           acc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: {HI, LO}
  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (f == F_MULT)  return sa * sb;
    if (f == F_MULTU) return ua * ub;
    if (b == '0) return {a, 32'hFFFF_FFFF};
    if (f == F_DIV) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Cycles from the accept edge to the edge that raises md_done
  function automatic int exp_lat(input logic [5:0] f, input logic [W-1:0] b);
    int l;
`ifdef MDU_EARLY_TERM_EN
    logic [W-1:0] m;
`endif
    l = W + 1;
`ifdef MDU_EARLY_TERM_EN
    if (!f[1]) begin
      m = (!f[0] && b[W-1]) ? -b : b;
      l = 2;
      for (int i = 0; i < W; i++) if (m[i]) l = i + 2;
    end
`endif
    return l;
  endfunction

  // Monitor: compare HI/LO and latency when md_done pulses
  always @(negedge clk) begin
    if (rst_n && md_done) begin
      if (tag_q.size() == 0) begin
        check("unexpected md_done", 64'd1, 64'd0);
      end else begin
        string       t;
        logic [63:0] e;
        int          l, a;
        t = tag_q.pop_front();
        e = hilo_q.pop_front();
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        check({t, " latency"}, 64'(cyc - a), 64'(l));
        check({t, " hi"}, 64'(hi), 64'(e[63:32]));
        check({t, " lo"}, 64'(lo), 64'(e[31:0]));
        check({t, " busy at done"}, 64'(md_busy), 64'd0);
      end
    end
  end

  task automatic dec_chk(input logic [1:0] ao, input logic [5:0] o, input logic [5:0] f,
                         input logic [2:0] exp, input string tag);
    aluop = ao;
    op    = o;
    funct = f;
    #1;
    check({"decode ", tag}, 64'(aluctrl), 64'(exp));
  endtask

  // Drive an MD op, wait for acceptance, queue its expectation
  task automatic md_issue(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp, input bit exp_stall);
    int waited;
    waited = 0;
    @(negedge clk);
    aluop = 2'b10;
    op    = 6'b000000;
    funct = f;
    src_a = a;
    src_b = b;
    issue = 1'b1;
    #1;
    check({tag, " stall on issue"}, 64'(stall), 64'(exp_stall));
    while (stall && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({tag, " accepted"}, 64'(stall), 64'd0);
    @(negedge clk);
    tag_q.push_back(tag);
    hilo_q.push_back(exp);
    lat_q.push_back(exp_lat(f, b));
    acc_q.push_back(cyc);
    issue = 1'b0;
    #1;
    check({tag, " busy after accept"}, 64'(md_busy), 64'd1);
  endtask

  // Wait until every queued op has completed and the FSM is back in IDLE
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((tag_q.size() != 0 || md_busy) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, " drained"}, 64'(tag_q.size()), 64'd0);
    @(negedge clk);
    #1;
    check({tag, " done is one cycle"}, 64'(md_done), 64'd0);
  endtask

  initial begin
    logic [5:0]   f;
    logic [W-1:0] a, b;
    int           n;

    // Decode sweep (combinational, in reset)
    dec_chk(2'b10, 6'b000000, 6'b100111, 3'b101, "nor");
    dec_chk(2'b10, 6'b001101, 6'b000000, 3'b011, "ori");
    dec_chk(2'b11, 6'b000000, 6'b000000, 3'b111, "bne");
    dec_chk(2'b10, 6'b000000, F_MULT,    3'b000, "mult");
    dec_chk(2'b01, 6'b000000, 6'b100111, 3'b001, "beq");
    dec_chk(2'b00, 6'b000000, 6'b100010, 3'b000, "lw/sw");
    dec_chk(2'b10, 6'b000000, 6'b100010, 3'b001, "sub");
    dec_chk(2'b10, 6'b000000, 6'b100100, 3'b010, "and");
    dec_chk(2'b10, 6'b000000, 6'b100110, 3'b100, "xor");
    dec_chk(2'b10, 6'b000000, 6'b101010, 3'b110, "slt");
    dec_chk(2'b10, 6'b001010, 6'b000000, 3'b110, "slti");
    dec_chk(2'b10, 6'b001110, 6'b000000, 3'b100, "xori");
    dec_chk(2'b10, 6'b001100, 6'b000000, 3'b010, "andi");
    dec_chk(2'b10, 6'b000000, F_MFLO,    3'b000, "mflo");
    dec_chk(2'b10, 6'b000100, 6'b000000, 3'b000, "other op");

    // Reset state
    aluop = 2'b10; op = '0; funct = F_DIV; issue = 1'b1;
    #1;
    check("reset busy", 64'(md_busy), 64'd0);
    check("reset done", 64'(md_done), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    issue = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    md_issue("mult 7*-6", F_MULT, 32'd7, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    drain("mult 7*-6");
    md_issue("divu 100/7", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    drain("divu 100/7");

    // mfhi reads HI combinationally while idle
    aluop = 2'b10; op = '0; funct = F_MFHI; issue = 1'b1;
    #1;
    check("mfhi stall idle", 64'(stall), 64'd0);
    check("mfhi hilo_rd", 64'(hilo_rd), 64'd1);
    check("mfhi data", 64'(hilo_data), 64'd2);
    issue = 1'b0;

    md_issue("div -100/7", F_DIV, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);
    drain("div -100/7");
    md_issue("div 0x1234/0", F_DIV, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1'b0);
    drain("div 0x1234/0");
    md_issue("div -5/0", F_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
    drain("div -5/0");
    md_issue("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
    drain("div ovf");
    md_issue("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    drain("multu max");
    md_issue("mult min*min", F_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    drain("mult min*min");
    md_issue("mult 3*5", F_MULT, 32'd3, 32'd5, 64'd15, 1'b0);
    drain("mult 3*5");

    // mflo issued while a multiply is in flight stalls until IDLE
    md_issue("mult for mflo", F_MULT, 32'h1234, 32'h4000_0000,
             model(F_MULT, 32'h1234, 32'h4000_0000), 1'b0);
    repeat (4) @(negedge clk);
    aluop = 2'b10; op = '0; funct = F_MFLO; issue = 1'b1;
    #1;
    check("mflo stalled", 64'(stall), 64'd1);
    check("mflo hilo_rd", 64'(hilo_rd), 64'd1);
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mflo released", 64'(stall), 64'd0);
    check("mflo after result", 64'(tag_q.size()), 64'd0);
    check("mflo data", 64'(hilo_data), 64'(model(F_MULT, 32'h1234, 32'h4000_0000) & 64'hFFFF_FFFF));
    check("mflo busy", 64'(md_busy), 64'd0);
    issue = 1'b0;

    // Second mult while busy: held, then runs
    md_issue("mult A", F_MULT, 32'd3, 32'd5, 64'd15, 1'b0);
    md_issue("mult B", F_MULT, 32'hFFFF_FFF9, 32'd9, model(F_MULT, 32'hFFFF_FFF9, 32'd9), 1'b1);
    drain("back to back");

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      f = F_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 300)) : $urandom;
      md_issue($sformatf("rand%0d f=%0h a=%0h b=%0h", i, f, a, b), f, a, b, model(f, a, b), 1'b0);
      drain("rand");
    end

    // Asynchronous reset in the middle of a divide
    md_issue("div rst", F_DIV, 32'h7654_3210, 32'd3, model(F_DIV, 32'h7654_3210, 32'd3), 1'b0);
    repeat (9) @(negedge clk);
    #1;
    check("pre-reset busy", 64'(md_busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(md_busy), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    check("async rst done", 64'(md_done), 64'd0);
    aluop = 2'b10; op = '0; funct = F_MFLO; issue = 1'b1;
    #1;
    check("async rst stall", 64'(stall), 64'd0);
    check("async rst hilo_data", 64'(hilo_data), 64'd0);
    issue = 1'b0;
    tag_q.delete();
    hilo_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    md_issue("divu after rst", F_DIVU, 32'd1000, 32'd33, {32'd10, 32'd30}, 1'b0);
    drain("divu after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
